btb_ctrl: RTL

//  Controller for an array of BTB entries. Fetch side: combines per-entry hit/prediction/target

---
 rtl/btb_pkg.sv | 34 +++
 rtl/btb_victim_sel.sv | 28 ++
 rtl/btb_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/btb_pkg.sv
// Shared definitions for the BTB controller: entry op-codes, PC/tag geometry,
// controller state encoding and the lowest-index priority encoder.
package btb_pkg;

  localparam int PC_W        = 16;
  localparam int TAG_HI      = 15;
  localparam int TAG_LO      = 5;
  localparam int TAG_W       = TAG_HI - TAG_LO + 1;
  localparam int MAX_ENTRIES = 32;

  localparam logic [2:0] OP_IDLE    = 3'b000;
  localparam logic [2:0] OP_VER_FT  = 3'b010;
  localparam logic [2:0] OP_VER_TGT = 3'b011;
  localparam logic [2:0] OP_INS_FT  = 3'b100;
  localparam logic [2:0] OP_INS_TGT = 3'b101;
  localparam logic [2:0] OP_CLEAR   = 3'b111;

  typedef enum logic [1:0] {
    ST_CLR  = 2'd0,
    ST_IDLE = 2'd1,
    ST_UPD  = 2'd2
  } state_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [4:0] lowest_set(input logic [MAX_ENTRIES-1:0] vec);
    logic [4:0] idx;
    idx = '0;
    for (int i = MAX_ENTRIES - 1; i >= 0; i--) begin
      if (vec[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/btb_victim_sel.sv
// Insert-victim selection: first empty entry if any exist, otherwise the
// round-robin pointer, which the caller advances when rr_advance is set.
module btb_victim_sel #(
  parameter int ENTRIES = 4,
  parameter int IDX_W   = 2
) (
  input  logic [ENTRIES-1:0] empty,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [ENTRIES-1:0] victim,
  output logic               rr_advance
);
  import btb_pkg::*;

  logic [MAX_ENTRIES-1:0] empty_ext;
  logic [IDX_W-1:0]       first_empty;

  assign empty_ext   = MAX_ENTRIES'(empty);
  assign first_empty = IDX_W'(lowest_set(empty_ext));
  assign rr_advance  = ~|empty;

  // One-hot victim: empty entries are always preferred over eviction.
  always_comb begin
    victim = '0;
    if (rr_advance) victim[rr_ptr]      = 1'b1;
    else            victim[first_empty] = 1'b1;
  end

endmodule

// File: rtl/btb_ctrl.sv
// BTB array controller: fetch-side next-PC prediction, execute-side
// verify/insert sequencing, victim choice and registered mispredict redirect.
module btb_ctrl #(
  parameter int ENTRIES = 4,
  parameter int PC_W    = btb_pkg::PC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PC_W-1:0]         fetch_pc,
  output logic                    pred_hit,
  output logic                    pred_taken,
  output logic [PC_W-1:0]         pred_next_pc,
  input  logic                    ex_valid,
  output logic                    ex_ready,
  input  logic [PC_W-1:0]         ex_pc,
  input  logic                    ex_taken,
  input  logic [PC_W-1:0]         ex_target,
  input  logic                    flush_btb,
  output logic                    redirect,
  output logic [PC_W-1:0]         redirect_pc,
  output logic [2:0]              btb_op,
  output logic [ENTRIES-1:0]      btb_en,
  output logic [11:0]             btb_in_pc,
  output logic [PC_W-1:0]         btb_in_target,
  input  logic [ENTRIES-1:0]      btb_hit,
  input  logic [ENTRIES-1:0]      btb_update_hit,
  input  logic [ENTRIES-1:0]      btb_prediction,
  input  logic [ENTRIES-1:0]      btb_empty,
  input  logic [ENTRIES*PC_W-1:0] btb_out_target
);
  import btb_pkg::*;

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  state_t state, state_nxt;

  // fetch side
  logic [IDX_W-1:0] sel;

  // execute side, combinational view of the presented branch
  logic             accept;
  logic             uhit;
  logic [IDX_W-1:0] usel;
  logic             upred;
  logic [PC_W-1:0]  ustored;
  logic             redir_cond;
  logic [PC_W-1:0]  redir_pc;

  // request captured at acceptance, consumed in UPD
  logic [PC_W-1:0]  req_pc_p1;
  logic             req_taken_p1;
  logic [PC_W-1:0]  req_target_p1;
  logic             uhit_p1;
  logic [IDX_W-1:0] usel_p1;
  logic [PC_W-1:0]  ustored_p1;

  // victim selection
  logic [IDX_W-1:0]   rr_ptr;
  logic [ENTRIES-1:0] victim;
  logic               rr_advance;
  logic               rr_step;

  btb_victim_sel #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_victim (
    .empty      (btb_empty),
    .rr_ptr     (rr_ptr),
    .victim     (victim),
    .rr_advance (rr_advance)
  );

  assign ex_ready = (state == ST_IDLE);
  assign accept   = ex_ready & ex_valid & ~flush_btb;

  // Fetch prediction: duplicate tag matches resolve to the lowest entry.
  always_comb begin
    sel          = IDX_W'(lowest_set(MAX_ENTRIES'(btb_hit)));
    pred_hit     = |btb_hit;
    pred_taken   = pred_hit & btb_prediction[sel];
    pred_next_pc = pred_taken ? btb_out_target[sel*PC_W +: PC_W] : fetch_pc + PC_W'(2);
  end

  // Look up the resolved branch and decide whether the front end must be redirected.
  always_comb begin
    usel       = IDX_W'(lowest_set(MAX_ENTRIES'(btb_update_hit)));
    uhit       = |btb_update_hit;
    upred      = btb_prediction[usel];
    ustored    = btb_out_target[usel*PC_W +: PC_W];
    redir_cond = 1'b0;
    redir_pc   = ex_target;
    if (uhit) begin
      if (upred != ex_taken) begin
        redir_cond = 1'b1;
        redir_pc   = ex_taken ? ex_target : ex_pc + PC_W'(2);
      end else if (ex_taken && upred && (ustored != ex_target)) begin
        redir_cond = 1'b1;
      end
    end else begin
      redir_cond = ex_taken;
    end
  end

  // Next state and entry-array command; all outputs decode from registered state.
  always_comb begin
    state_nxt     = state;
    btb_op        = OP_IDLE;
    btb_en        = '0;
    btb_in_pc     = {1'b0, ex_pc[TAG_HI:TAG_LO]};
    btb_in_target = ex_target;
    rr_step       = 1'b0;
    case (state)
      ST_CLR: begin
        btb_op    = OP_CLEAR;
        btb_en    = '1;
        state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (accept) state_nxt = ST_UPD;
      end
      ST_UPD: begin
        btb_in_pc     = {1'b0, req_pc_p1[TAG_HI:TAG_LO]};
        btb_in_target = req_target_p1;
        if (uhit_p1) begin
          btb_en[usel_p1] = 1'b1;
          if (req_taken_p1 && (ustored_p1 != req_target_p1)) btb_op = OP_INS_TGT;
          else btb_op = req_taken_p1 ? OP_VER_TGT : OP_VER_FT;
        end else begin
          btb_en  = victim;
          btb_op  = req_taken_p1 ? OP_INS_TGT : OP_INS_FT;
          rr_step = rr_advance;
        end
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_CLR;
    endcase
    if (flush_btb) state_nxt = ST_CLR;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_CLR;
    else     state <= state_nxt;
  end

  // Redirect pulse and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect    <= 1'b0;
      redirect_pc <= '0;
      rr_ptr      <= '0;
    end else begin
      redirect <= accept & redir_cond;
      if (accept) redirect_pc <= redir_pc;
      if (rr_step) rr_ptr <= (rr_ptr == IDX_W'(ENTRIES - 1)) ? '0 : rr_ptr + IDX_W'(1);
    end
  end

  // Capture the accepted request and its lookup result for the UPD cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_pc_p1     <= ex_pc;
      req_taken_p1  <= ex_taken;
      req_target_p1 <= ex_target;
      uhit_p1       <= uhit;
      usel_p1       <= usel;
      ustored_p1    <= ustored;
    end
  end

endmodule
